hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
// PURPOSE
//   Pipeline control for the 5-stage MIPS core. Detects load-use and branch-operand hazards.
//   Drives stall/flush for the fetch, decode and execute stages, and forwarding selects for decode and execute.
//   Tracks outstanding instruction-fetch waits with a timeout FSM.
//   Keeps saturating stall/flush counters. Sits beside the datapath; it only sequences it.
// PARAMETERS
//   REG_AW        5    register-address width
//   CNT_W         16   width of stall_cnt / flush_cnt
//   IMEM_TIMEOUT  15   consecutive WAIT cycles before fetch_err (>=1)
// PORTS
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous, active-low reset
//   rsD,rtD     in   REG_AW decode-stage source regs
//   rsE,rtE     in   REG_AW execute-stage source regs
//   writeRegE/M/W in REG_AW destination reg in E/M/W
//   regWriteE/M/W in 1      destination write enable in E/M/W
//   memToRegE/M in   1      instruction in E/M is a load
//   branchD     in   1      decode holds a branch
//   PCSrcD      in   1      branch resolved taken in decode
//   fetch_valid in   1      imem returned the instruction this cycle
//   stallF      out  1      hold PC / fetch
//   stallD      out  1      hold IF/ID register
//   flushD      out  1      bubble IF/ID register
//   flushE      out  1      bubble ID/EX register
//   forwardAD,forwardBD out 1   decode compare operand from M stage
//   forwardAE,forwardBE out 2   00 regfile, 01 W result, 10 M result
//   fetch_err   out  1      sticky fetch-timeout flag
//   stall_cnt   out  CNT_W  cycles with stallD=1
//   flush_cnt   out  CNT_W  taken-branch flushes
// BEHAVIOUR
//   match(r,en,d) = en & (d!=0) & (d==r). Register 0 is never a hazard or forward source.
//   lwstall = memToRegE & (match(rsD,regWriteE,writeRegE) | match(rtD,regWriteE,writeRegE)).
//   brstall = branchD & (match(rsD/rtD,regWriteE,writeRegE) | match(rsD/rtD,memToRegM,writeRegM)).
//   hz = lwstall | brstall (combinational, same cycle).
//   fwd: AE/BE = 10 if match(rsE/rtE,regWriteM,writeRegM); else 01 if match W; else 00. M wins.
//   AD/BD = match(rsD/rtD,regWriteM,writeRegM).
//   FSM (2-bit): RUN, WAIT, ERR.
//     RUN: fetch_valid=0 -> WAIT; wcnt<=1.
//     WAIT: fetch_valid=1 -> RUN; else wcnt++, and wcnt==IMEM_TIMEOUT -> ERR.
//     ERR: absorbing until reset; fetch_err=1.
//     Any state except ERR: (PCSrcD & !hz) -> RUN, wcnt<=0 (redirect abandons pending fetch).
//   iwait = !fetch_valid & state!=ERR.
//   outputs (combinational from inputs+state):
//     stallD = hz | ERR
//     flushE = hz | ERR
//     stallF = ERR | hz | (iwait & !(PCSrcD & !hz))   // redirect wins over imem wait
//     flushD = !hz & !ERR & (PCSrcD | iwait)           // stall beats flush
//   counters: stall_cnt += stallD; flush_cnt += (PCSrcD & !hz & !ERR). Both saturate at all-ones.
//   reset (async, any time incl. mid-WAIT): state=RUN, wcnt=0, fetch_err=0, counters=0.
//   Combinational outputs follow inputs immediately after reset release.
// STRUCTURE
//   hazard_pkg: state encoding (RUN=0,WAIT=1,ERR=2), FWD_RF/FWD_W/FWD_M constants, REG_AW default.
//   One sub-module: sat_counter #(CNT_W) (en, clr via rst_n), instantiated twice.
//   Remainder flat: comb hazard/forward logic + FSM process.
// TESTING
//   1 lw $8 in E (memToRegE=1,writeRegE=8), rsD=8 -> stallF=stallD=flushE=1 for exactly that cycle;
//     next cycle (lw in M) hz=0, forwardAE=10 when rsE=8.
//   2 beq rsD=3 with writeRegE=3 regWriteE=1 -> brstall; then load in M to $3 -> stall again;
//     ALU result in M, not a load -> forwardAD=1, no stall.
//   3 writeRegM=writeRegW=5 both writing, rsE=5 -> forwardAE=10; writeRegM=0 with regWriteM=1, rsE=0 -> 00.
//   4 fetch_valid low 3 cycles then high -> stallF=flushD=1 for 3 cycles, state RUN after;
//     low IMEM_TIMEOUT+1 cycles -> fetch_err=1 and stays; rst_n pulse mid-WAIT -> RUN, err=0.
//   5 PCSrcD=1 with fetch_valid=0 and hz=0 -> stallF=0, flushD=1, FSM->RUN, flush_cnt+1;
//     PCSrcD=1 with lwstall -> flushD=0, stallD=1.
//   6 CNT_W=4, hold lwstall 20 cycles -> stall_cnt saturates at 15, no wrap.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
package hazard_pkg;

    // Fetch-wait FSM state encoding
    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    // Execute-stage forwarding select values
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Default register-address width (32 architectural registers)
    localparam int unsigned REG_AW_DEF = 5;

endpackage : hazard_pkg

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; cleared by reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count enabled cycles, holding once the maximum is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/hazard_controller.sv
// Pipeline hazard detection, forwarding selects, fetch-timeout tracking and
// stall/flush statistics for the 5-stage core.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW       = REG_AW_DEF,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned IMEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeRegE,
    input  logic [REG_AW-1:0] writeRegM,
    input  logic [REG_AW-1:0] writeRegW,
    input  logic              regWriteE,
    input  logic              regWriteM,
    input  logic              regWriteW,
    input  logic              memToRegE,
    input  logic              memToRegM,
    input  logic              branchD,
    input  logic              PCSrcD,
    input  logic              fetch_valid,
    output logic              stallF,
    output logic              stallD,
    output logic              flushD,
    output logic              flushE,
    output logic              forwardAD,
    output logic              forwardBD,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              fetch_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Wait counter must be able to hold IMEM_TIMEOUT itself
    localparam int unsigned WCNT_W = $clog2(IMEM_TIMEOUT + 1);

    // Register 0 is hardwired zero, so it never creates a dependency
    function automatic logic reg_match(input logic [REG_AW-1:0] r,
                                       input logic              en,
                                       input logic [REG_AW-1:0] d);
        return en && (d != '0) && (d == r);
    endfunction

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_nxt;

    logic lwstall;
    logic brstall;
    logic hz;
    logic in_err;
    logic iwait;
    logic redirect;

    // Load-use and branch-operand hazard detection
    always_comb begin
        lwstall = memToRegE && (reg_match(rsD, regWriteE, writeRegE) ||
                                reg_match(rtD, regWriteE, writeRegE));
        brstall = branchD && (reg_match(rsD, regWriteE, writeRegE) ||
                              reg_match(rtD, regWriteE, writeRegE) ||
                              reg_match(rsD, memToRegM, writeRegM) ||
                              reg_match(rtD, memToRegM, writeRegM));
        hz      = lwstall || brstall;
    end

    // Forwarding selects; the younger M-stage result wins over W
    always_comb begin
        forwardAE = FWD_RF;
        forwardBE = FWD_RF;
        if (reg_match(rsE, regWriteM, writeRegM)) begin
            forwardAE = FWD_M;
        end else if (reg_match(rsE, regWriteW, writeRegW)) begin
            forwardAE = FWD_W;
        end
        if (reg_match(rtE, regWriteM, writeRegM)) begin
            forwardBE = FWD_M;
        end else if (reg_match(rtE, regWriteW, writeRegW)) begin
            forwardBE = FWD_W;
        end
        forwardAD = reg_match(rsD, regWriteM, writeRegM);
        forwardBD = reg_match(rtD, regWriteM, writeRegM);
    end

    // Stall/flush steering: a hazard stall beats a flush, a redirect beats an imem wait
    always_comb begin
        in_err    = (state == ST_ERR);
        iwait     = !fetch_valid && !in_err;
        redirect  = PCSrcD && !hz;
        stallD    = hz || in_err;
        flushE    = hz || in_err;
        stallF    = in_err || hz || (iwait && !redirect);
        flushD    = !hz && !in_err && (PCSrcD || iwait);
        fetch_err = in_err;
    end

    // Fetch-wait FSM state and wait-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Fetch-wait FSM next state; a taken redirect abandons any pending fetch
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            ST_RUN: begin
                if (!fetch_valid) begin
                    state_nxt = ST_WAIT;
                    wcnt_nxt  = WCNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (fetch_valid) begin
                    state_nxt = ST_RUN;
                end else begin
                    wcnt_nxt = wcnt + WCNT_W'(1);
                    if (wcnt == WCNT_W'(IMEM_TIMEOUT)) begin
                        state_nxt = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                state_nxt = ST_ERR;
            end
            default: begin
                state_nxt = ST_RUN;
                wcnt_nxt  = '0;
            end
        endcase
        if (!in_err && redirect) begin
            state_nxt = ST_RUN;
            wcnt_nxt  = '0;
        end
    end

    // Statistics: decode-stall cycles and taken-branch flushes
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stallD),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (redirect && !in_err),
        .count (flush_cnt)
    );

endmodule : hazard_controller

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: hazards, forwarding, fetch timeout,
// redirect priority and counter saturation (second instance with 4-bit counters).
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
    logic       regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
    logic       branchD, PCSrcD, fetch_valid;

    logic        stallF, stallD, flushD, flushE, forwardAD, forwardBD, fetch_err;
    logic [1:0]  forwardAE, forwardBE;
    logic [15:0] stall_cnt, flush_cnt;

    logic        stallF4, stallD4, flushD4, flushE4, forwardAD4, forwardBD4, fetch_err4;
    logic [1:0]  forwardAE4, forwardBE4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_controller dut (
        .clk(clk), .rst_n(rst_n),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
        .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .memToRegE(memToRegE), .memToRegM(memToRegM),
        .branchD(branchD), .PCSrcD(PCSrcD), .fetch_valid(fetch_valid),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .fetch_err(fetch_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_controller #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
        .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .memToRegE(memToRegE), .memToRegM(memToRegM),
        .branchD(branchD), .PCSrcD(PCSrcD), .fetch_valid(fetch_valid),
        .stallF(stallF4), .stallD(stallD4), .flushD(flushD4), .flushE(flushE4),
        .forwardAD(forwardAD4), .forwardBD(forwardBD4),
        .forwardAE(forwardAE4), .forwardBE(forwardBE4),
        .fetch_err(fetch_err4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeRegE = '0; writeRegM = '0; writeRegW = '0;
        regWriteE = 1'b0; regWriteM = 1'b0; regWriteW = 1'b0;
        memToRegE = 1'b0; memToRegM = 1'b0;
        branchD = 1'b0; PCSrcD = 1'b0; fetch_valid = 1'b1;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_ctl(input string tag, input logic sf, input logic sd,
                             input logic fd, input logic fe);
        check({tag, ".stallF"}, 32'(stallF), 32'(sf));
        check({tag, ".stallD"}, 32'(stallD), 32'(sd));
        check({tag, ".flushD"}, 32'(flushD), 32'(fd));
        check({tag, ".flushE"}, 32'(flushE), 32'(fe));
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        ticks(2);
        check("rst.stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst.flush_cnt", 32'(flush_cnt), 32'd0);
        check("rst.fetch_err", 32'(fetch_err), 32'd0);
        rst_n = 1'b1;
        #1;
        check_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);

        // 1: load-use stall for one cycle, then M->E forward
        memToRegE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd8; rsD = 5'd8;
        #1;
        check_ctl("lw", 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        memToRegM = 1'b1; regWriteM = 1'b1; writeRegM = 5'd8; rsE = 5'd8;
        #1;
        check_ctl("lw_next", 1'b0, 1'b0, 1'b0, 1'b0);
        check("lw_next.forwardAE", 32'(forwardAE), 32'd2);
        check("lw_next.forwardBE", 32'(forwardBE), 32'd0);
        tick();

        // 2: branch operand hazards and decode forwarding
        idle();
        branchD = 1'b1; rsD = 5'd3; writeRegE = 5'd3; regWriteE = 1'b1;
        #1;
        check("br_aluE.stallD", 32'(stallD), 32'd1);
        regWriteE = 1'b0; writeRegE = 5'd0;
        memToRegM = 1'b1; regWriteM = 1'b1; writeRegM = 5'd3;
        #1;
        check("br_ldM.stallD", 32'(stallD), 32'd1);
        memToRegM = 1'b0;
        #1;
        check("br_aluM.stallD", 32'(stallD), 32'd0);
        check("br_aluM.forwardAD", 32'(forwardAD), 32'd1);
        check("br_aluM.forwardBD", 32'(forwardBD), 32'd0);
        rsD = 5'd0; rtD = 5'd3;
        #1;
        check("br_aluM.rt.forwardBD", 32'(forwardBD), 32'd1);
        check("br_aluM.rt.forwardAD", 32'(forwardAD), 32'd0);
        tick();

        // 3: execute forwarding priority and register 0
        idle();
        writeRegM = 5'd5; regWriteM = 1'b1; writeRegW = 5'd5; regWriteW = 1'b1;
        rsE = 5'd5; rtE = 5'd5;
        #1;
        check("fwd_MW.forwardAE", 32'(forwardAE), 32'd2);
        check("fwd_MW.forwardBE", 32'(forwardBE), 32'd2);
        regWriteM = 1'b0;
        #1;
        check("fwd_W.forwardAE", 32'(forwardAE), 32'd1);
        writeRegM = 5'd0; regWriteM = 1'b1; writeRegW = 5'd0; rsE = 5'd0; rtE = 5'd0;
        #1;
        check("fwd_r0.forwardAE", 32'(forwardAE), 32'd0);
        check("fwd_r0.forwardBE", 32'(forwardBE), 32'd0);
        tick();

        // 4: short imem wait, then a timeout into ERR
        idle();
        fetch_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_ctl($sformatf("iwait%0d", i), 1'b1, 1'b0, 1'b1, 1'b0);
            tick();
        end
        fetch_valid = 1'b1;
        #1;
        check_ctl("iwait_done", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        fetch_valid = 1'b0;
        ticks(15);
        check("tmo15.fetch_err", 32'(fetch_err), 32'd0);
        tick();
        check("tmo16.fetch_err", 32'(fetch_err), 32'd1);
        fetch_valid = 1'b1;
        ticks(3);
        check("err_sticky.fetch_err", 32'(fetch_err), 32'd1);
        check_ctl("err", 1'b1, 1'b1, 1'b0, 1'b1);
        PCSrcD = 1'b1;
        #1;
        check("err_redirect.flushD", 32'(flushD), 32'd0);
        PCSrcD = 1'b0;

        // async reset out of ERR, then again in the middle of a WAIT
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        check("rst_err.fetch_err", 32'(fetch_err), 32'd0);
        tick();
        fetch_valid = 1'b0;
        ticks(2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_wait.fetch_err", 32'(fetch_err), 32'd0);
        check("rst_wait.stall_cnt", 32'(stall_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        // 15 low cycles from RUN must not time out if the wait count was cleared
        ticks(15);
        check("post_rst.fetch_err", 32'(fetch_err), 32'd0);
        check("post_rst.stall_cnt", 32'(stall_cnt), 32'd0);
        fetch_valid = 1'b1;
        tick();

        // 5: redirect wins over imem wait; a hazard stall beats the flush
        fetch_valid = 1'b0;
        tick();
        PCSrcD = 1'b1; branchD = 1'b1;
        #1;
        check_ctl("redir_wait", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("redir.flush_cnt", 32'(flush_cnt), 32'd1);
        idle();
        PCSrcD = 1'b1;
        memToRegE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd8; rsD = 5'd8;
        #1;
        check_ctl("redir_lw", 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check("redir_lw.flush_cnt", 32'(flush_cnt), 32'd1);
        check("redir_lw.stall_cnt", 32'(stall_cnt), 32'd1);
        PCSrcD = 1'b0;

        // 6: 4-bit counter saturates, 16-bit keeps counting
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        ticks(15);
        check("sat15.stall_cnt4", 32'(stall_cnt4), 32'd15);
        ticks(5);
        check("sat20.stall_cnt4", 32'(stall_cnt4), 32'd15);
        check("sat20.stall_cnt", 32'(stall_cnt), 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_hazard_controller
